// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) / state-permutation helpers for the
// iterative cipher core.
package aes_pkg;

    typedef logic [127:0] block_t;
    typedef logic [31:0]  word_t;

    localparam logic [3:0] NR = 4'd10;

    // Indexed directly by the 4-bit round counter; unused slots stay zero.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t mix_column(input word_t col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Column-major layout: byte i sits at row i%4, column i/4.
    function automatic block_t shift_rows(input block_t s);
        block_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes128_encrypt_if.sv
// Request/response bundle between a mode wrapper and the AES-128 cipher core.
interface aes128_encrypt_if;
    import aes_pkg::*;

    logic   start;
    block_t key;
    block_t plaintext;
    logic   busy;
    logic   done;
    block_t ciphertext;

    modport master (output start, key, plaintext, input busy, done, ciphertext);
    modport slave  (input start, key, plaintext, output busy, done, ciphertext);
endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box as a purely combinational 256-entry ROM.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    always_comb begin
        y = 8'h00;
        case (a)
            8'h00: y = 8'h63; 8'h01: y = 8'h7c; 8'h02: y = 8'h77; 8'h03: y = 8'h7b; 8'h04: y = 8'hf2; 8'h05: y = 8'h6b; 8'h06: y = 8'h6f; 8'h07: y = 8'hc5;
            8'h08: y = 8'h30; 8'h09: y = 8'h01; 8'h0a: y = 8'h67; 8'h0b: y = 8'h2b; 8'h0c: y = 8'hfe; 8'h0d: y = 8'hd7; 8'h0e: y = 8'hab; 8'h0f: y = 8'h76;
            8'h10: y = 8'hca; 8'h11: y = 8'h82; 8'h12: y = 8'hc9; 8'h13: y = 8'h7d; 8'h14: y = 8'hfa; 8'h15: y = 8'h59; 8'h16: y = 8'h47; 8'h17: y = 8'hf0;
            8'h18: y = 8'had; 8'h19: y = 8'hd4; 8'h1a: y = 8'ha2; 8'h1b: y = 8'haf; 8'h1c: y = 8'h9c; 8'h1d: y = 8'ha4; 8'h1e: y = 8'h72; 8'h1f: y = 8'hc0;
            8'h20: y = 8'hb7; 8'h21: y = 8'hfd; 8'h22: y = 8'h93; 8'h23: y = 8'h26; 8'h24: y = 8'h36; 8'h25: y = 8'h3f; 8'h26: y = 8'hf7; 8'h27: y = 8'hcc;
            8'h28: y = 8'h34; 8'h29: y = 8'ha5; 8'h2a: y = 8'he5; 8'h2b: y = 8'hf1; 8'h2c: y = 8'h71; 8'h2d: y = 8'hd8; 8'h2e: y = 8'h31; 8'h2f: y = 8'h15;
            8'h30: y = 8'h04; 8'h31: y = 8'hc7; 8'h32: y = 8'h23; 8'h33: y = 8'hc3; 8'h34: y = 8'h18; 8'h35: y = 8'h96; 8'h36: y = 8'h05; 8'h37: y = 8'h9a;
            8'h38: y = 8'h07; 8'h39: y = 8'h12; 8'h3a: y = 8'h80; 8'h3b: y = 8'he2; 8'h3c: y = 8'heb; 8'h3d: y = 8'h27; 8'h3e: y = 8'hb2; 8'h3f: y = 8'h75;
            8'h40: y = 8'h09; 8'h41: y = 8'h83; 8'h42: y = 8'h2c; 8'h43: y = 8'h1a; 8'h44: y = 8'h1b; 8'h45: y = 8'h6e; 8'h46: y = 8'h5a; 8'h47: y = 8'ha0;
            8'h48: y = 8'h52; 8'h49: y = 8'h3b; 8'h4a: y = 8'hd6; 8'h4b: y = 8'hb3; 8'h4c: y = 8'h29; 8'h4d: y = 8'he3; 8'h4e: y = 8'h2f; 8'h4f: y = 8'h84;
            8'h50: y = 8'h53; 8'h51: y = 8'hd1; 8'h52: y = 8'h00; 8'h53: y = 8'hed; 8'h54: y = 8'h20; 8'h55: y = 8'hfc; 8'h56: y = 8'hb1; 8'h57: y = 8'h5b;
            8'h58: y = 8'h6a; 8'h59: y = 8'hcb; 8'h5a: y = 8'hbe; 8'h5b: y = 8'h39; 8'h5c: y = 8'h4a; 8'h5d: y = 8'h4c; 8'h5e: y = 8'h58; 8'h5f: y = 8'hcf;
            8'h60: y = 8'hd0; 8'h61: y = 8'hef; 8'h62: y = 8'haa; 8'h63: y = 8'hfb; 8'h64: y = 8'h43; 8'h65: y = 8'h4d; 8'h66: y = 8'h33; 8'h67: y = 8'h85;
            8'h68: y = 8'h45; 8'h69: y = 8'hf9; 8'h6a: y = 8'h02; 8'h6b: y = 8'h7f; 8'h6c: y = 8'h50; 8'h6d: y = 8'h3c; 8'h6e: y = 8'h9f; 8'h6f: y = 8'ha8;
            8'h70: y = 8'h51; 8'h71: y = 8'ha3; 8'h72: y = 8'h40; 8'h73: y = 8'h8f; 8'h74: y = 8'h92; 8'h75: y = 8'h9d; 8'h76: y = 8'h38; 8'h77: y = 8'hf5;
            8'h78: y = 8'hbc; 8'h79: y = 8'hb6; 8'h7a: y = 8'hda; 8'h7b: y = 8'h21; 8'h7c: y = 8'h10; 8'h7d: y = 8'hff; 8'h7e: y = 8'hf3; 8'h7f: y = 8'hd2;
            8'h80: y = 8'hcd; 8'h81: y = 8'h0c; 8'h82: y = 8'h13; 8'h83: y = 8'hec; 8'h84: y = 8'h5f; 8'h85: y = 8'h97; 8'h86: y = 8'h44; 8'h87: y = 8'h17;
            8'h88: y = 8'hc4; 8'h89: y = 8'ha7; 8'h8a: y = 8'h7e; 8'h8b: y = 8'h3d; 8'h8c: y = 8'h64; 8'h8d: y = 8'h5d; 8'h8e: y = 8'h19; 8'h8f: y = 8'h73;
            8'h90: y = 8'h60; 8'h91: y = 8'h81; 8'h92: y = 8'h4f; 8'h93: y = 8'hdc; 8'h94: y = 8'h22; 8'h95: y = 8'h2a; 8'h96: y = 8'h90; 8'h97: y = 8'h88;
            8'h98: y = 8'h46; 8'h99: y = 8'hee; 8'h9a: y = 8'hb8; 8'h9b: y = 8'h14; 8'h9c: y = 8'hde; 8'h9d: y = 8'h5e; 8'h9e: y = 8'h0b; 8'h9f: y = 8'hdb;
            8'ha0: y = 8'he0; 8'ha1: y = 8'h32; 8'ha2: y = 8'h3a; 8'ha3: y = 8'h0a; 8'ha4: y = 8'h49; 8'ha5: y = 8'h06; 8'ha6: y = 8'h24; 8'ha7: y = 8'h5c;
            8'ha8: y = 8'hc2; 8'ha9: y = 8'hd3; 8'haa: y = 8'hac; 8'hab: y = 8'h62; 8'hac: y = 8'h91; 8'had: y = 8'h95; 8'hae: y = 8'he4; 8'haf: y = 8'h79;
            8'hb0: y = 8'he7; 8'hb1: y = 8'hc8; 8'hb2: y = 8'h37; 8'hb3: y = 8'h6d; 8'hb4: y = 8'h8d; 8'hb5: y = 8'hd5; 8'hb6: y = 8'h4e; 8'hb7: y = 8'ha9;
            8'hb8: y = 8'h6c; 8'hb9: y = 8'h56; 8'hba: y = 8'hf4; 8'hbb: y = 8'hea; 8'hbc: y = 8'h65; 8'hbd: y = 8'h7a; 8'hbe: y = 8'hae; 8'hbf: y = 8'h08;
            8'hc0: y = 8'hba; 8'hc1: y = 8'h78; 8'hc2: y = 8'h25; 8'hc3: y = 8'h2e; 8'hc4: y = 8'h1c; 8'hc5: y = 8'ha6; 8'hc6: y = 8'hb4; 8'hc7: y = 8'hc6;
            8'hc8: y = 8'he8; 8'hc9: y = 8'hdd; 8'hca: y = 8'h74; 8'hcb: y = 8'h1f; 8'hcc: y = 8'h4b; 8'hcd: y = 8'hbd; 8'hce: y = 8'h8b; 8'hcf: y = 8'h8a;
            8'hd0: y = 8'h70; 8'hd1: y = 8'h3e; 8'hd2: y = 8'hb5; 8'hd3: y = 8'h66; 8'hd4: y = 8'h48; 8'hd5: y = 8'h03; 8'hd6: y = 8'hf6; 8'hd7: y = 8'h0e;
            8'hd8: y = 8'h61; 8'hd9: y = 8'h35; 8'hda: y = 8'h57; 8'hdb: y = 8'hb9; 8'hdc: y = 8'h86; 8'hdd: y = 8'hc1; 8'hde: y = 8'h1d; 8'hdf: y = 8'h9e;
            8'he0: y = 8'he1; 8'he1: y = 8'hf8; 8'he2: y = 8'h98; 8'he3: y = 8'h11; 8'he4: y = 8'h69; 8'he5: y = 8'hd9; 8'he6: y = 8'h8e; 8'he7: y = 8'h94;
            8'he8: y = 8'h9b; 8'he9: y = 8'h1e; 8'hea: y = 8'h87; 8'heb: y = 8'he9; 8'hec: y = 8'hce; 8'hed: y = 8'h55; 8'hee: y = 8'h28; 8'hef: y = 8'hdf;
            8'hf0: y = 8'h8c; 8'hf1: y = 8'ha1; 8'hf2: y = 8'h89; 8'hf3: y = 8'h0d; 8'hf4: y = 8'hbf; 8'hf5: y = 8'he6; 8'hf6: y = 8'h42; 8'hf7: y = 8'h68;
            8'hf8: y = 8'h41; 8'hf9: y = 8'h99; 8'hfa: y = 8'h2d; 8'hfb: y = 8'h0f; 8'hfc: y = 8'hb0; 8'hfd: y = 8'h54; 8'hfe: y = 8'hbb; 8'hff: y = 8'h16;
            default: y = 8'h00;
        endcase
    end
endmodule

// File: rtl/aes128_encrypt.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded
// alongside the data path so no key-schedule storage is needed.
module aes128_encrypt
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    aes128_encrypt_if.slave  bus
);
    block_t     state_reg;
    block_t     rk_reg;
    block_t     ct_reg;
    logic [3:0] rnd_reg;
    logic       busy_reg;
    logic       done_reg;

    block_t     sub_bytes;
    block_t     shifted;
    block_t     mixed;
    block_t     rk_next;
    block_t     state_next;
    word_t      rot_word;
    word_t      sub_word;
    word_t      key_t;
    word_t      w0_next, w1_next, w2_next, w3_next;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sub_bytes
            aes_sbox u_sbox (
                .a (state_reg[127-8*gi -: 8]),
                .y (sub_bytes[127-8*gi -: 8])
            );
        end
    endgenerate

    assign shifted = shift_rows(sub_bytes);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mix
            assign mixed[127-32*gi -: 32] = mix_column(shifted[127-32*gi -: 32]);
        end
    endgenerate

    // On-the-fly key expansion from the last word of the current round key.
    assign rot_word = {rk_reg[23:0], rk_reg[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sub_word
            aes_sbox u_sbox (
                .a (rot_word[31-8*gi -: 8]),
                .y (sub_word[31-8*gi -: 8])
            );
        end
    endgenerate

    assign key_t   = sub_word ^ {RCON[rnd_reg], 24'h000000};
    assign w0_next = rk_reg[127:96] ^ key_t;
    assign w1_next = rk_reg[95:64]  ^ w0_next;
    assign w2_next = rk_reg[63:32]  ^ w1_next;
    assign w3_next = rk_reg[31:0]   ^ w2_next;
    assign rk_next = {w0_next, w1_next, w2_next, w3_next};

    // The last round skips MixColumns.
    assign state_next = ((rnd_reg == NR) ? shifted : mixed) ^ rk_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= '0;
            rk_reg    <= '0;
            ct_reg    <= '0;
            rnd_reg   <= 4'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (!busy_reg) begin
                if (bus.start) begin
                    state_reg <= bus.plaintext ^ bus.key;
                    rk_reg    <= bus.key;
                    rnd_reg   <= 4'd1;
                    busy_reg  <= 1'b1;
                end
            end else begin
                state_reg <= state_next;
                rk_reg    <= rk_next;
                if (rnd_reg == NR) begin
                    ct_reg   <= state_next;
                    done_reg <= 1'b1;
                    busy_reg <= 1'b0;
                    rnd_reg  <= 4'd0;
                end else begin
                    rnd_reg <= rnd_reg + 4'd1;
                end
            end
        end
    end

    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.ciphertext = ct_reg;

endmodule

// File: tb/tb_aes128_encrypt.sv
// Scoreboarded bench for the iterative AES-128 core: known answers, OFB chain,
// start filtering, back-to-back throughput, async reset abort, input sampling.
module tb_aes128_encrypt;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes128_encrypt_if bus ();

    aes128_encrypt dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K3 = 128'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [127:0] P3 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] C3 = 128'hff0b844a0853bf7c6934ab4364148fb9;
    localparam logic [127:0] P3_OFB = 128'h5468617473206d79204b756e67204675;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_count = 0;
    logic prev_done = 1'b0;

    logic [7:0]   sbox_sw [256];
    logic [127:0] exp_q [$];
    int           acc_q [$];
    int           done_cyc [$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box derived from the field inverse plus affine map, not from a table.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int v = 0; v < 256; v++) begin
            b = 8'(v);
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, b);
            if (v == 0) inv = 8'h00;
            sbox_sw[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                       ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_sw[tmp[23:16]], sbox_sw[tmp[15:8]], sbox_sw[tmp[7:0]], sbox_sw[tmp[31:24]]}
                      ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_sw[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row+4*c] = t[row + 4*((c+row)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // Scoreboard push at every edge the DUT should accept.
    always @(posedge clk) begin
        if (rst_n && bus.start && !bus.busy) begin
            exp_q.push_back(aes_model(bus.key, bus.plaintext));
            acc_q.push_back(cyc + 1);
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        logic [127:0] e;
        int a;
        if (rst_n && bus.done) begin
            check_eq("done_width", prev_done, 1'b0);
            if (exp_q.size() == 0) begin
                check_eq("spurious_done", bus.done, 1'b0);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check_eq("sb_ct", bus.ciphertext, e);
                check_eq("latency", cyc - a, 10);
            end
            done_cyc.push_back(cyc);
            done_count++;
            $display("blk %0d cyc=%0d ct=%h", done_count, cyc, bus.ciphertext);
        end
        prev_done <= bus.done;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_seen", bus.busy, 1'b0);
    endtask

    task automatic wait_done(output logic [127:0] ct);
        int n;
        n = 0;
        while (!bus.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_seen", bus.done, 1'b1);
        ct = bus.ciphertext;
    endtask

    task automatic run_block(input logic [127:0] k, input logic [127:0] p, output logic [127:0] ct);
        wait_idle();
        bus.start = 1'b1;
        bus.key = k;
        bus.plaintext = p;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(ct);
    endtask

    initial begin
        logic [127:0] ct;
        logic [127:0] chain;
        logic [127:0] model_chain;
        int dc0;
        int nd;
        int seen;
        int n;

        build_sbox();
        bus.start = 1'b0;
        bus.key = '0;
        bus.plaintext = '0;

        repeat (2) @(negedge clk);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_done", bus.done, 1'b0);
        check_eq("rst_ct", bus.ciphertext, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer vectors.
        run_block(K1, P1, ct);
        check_eq("kat_b", ct, C1);
        check_eq("busy_after_done", bus.busy, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("ct_hold", bus.ciphertext, C1);
        check_eq("done_low", bus.done, 1'b0);

        run_block(K2, P2, ct);
        check_eq("kat_c1", ct, C2);
        run_block(K3, P3, ct);
        check_eq("kat_3", ct, C3);

        // OFB: previous ciphertext becomes next plaintext.
        chain = P3_OFB;
        model_chain = P3_OFB;
        for (int i = 0; i < 1000; i++) begin
            run_block(K3, chain, ct);
            chain = ct;
            model_chain = aes_model(K3, model_chain);
        end
        check_eq("ofb_final", chain, model_chain);

        // Starts raised mid-block must be ignored.
        @(negedge clk);
        dc0 = done_count;
        bus.start = 1'b1; bus.key = K1; bus.plaintext = P1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.key = K2; bus.plaintext = P2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.key = K3; bus.plaintext = P3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(ct);
        check_eq("ignore_ct", ct, C1);
        repeat (12) @(negedge clk);
        check_eq("ignore_dones", done_count - dc0, 1);
        check_eq("ignore_ct_hold", bus.ciphertext, C1);

        // Held start: back-to-back blocks every 11 cycles.
        dc0 = done_count;
        nd = done_cyc.size();
        bus.start = 1'b1; bus.key = K2; bus.plaintext = P2;
        n = 0;
        seen = 0;
        while (seen < 3 && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.done) seen++;
        end
        bus.start = 1'b0;
        check_eq("held_dones", seen, 3);
        repeat (12) @(negedge clk);
        check_eq("held_idle", bus.busy, 1'b0);
        check_eq("held_count", done_count - dc0, 3);
        if (done_cyc.size() >= nd + 3) begin
            check_eq("held_gap1", done_cyc[nd+1] - done_cyc[nd], 11);
            check_eq("held_gap2", done_cyc[nd+2] - done_cyc[nd+1], 11);
        end

        // Asynchronous reset in the middle of round 5.
        bus.start = 1'b1; bus.key = K3; bus.plaintext = P3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_busy", bus.busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", bus.busy, 1'b0);
        check_eq("arst_done", bus.done, 1'b0);
        check_eq("arst_ct", bus.ciphertext, '0);
        exp_q.delete();
        acc_q.delete();
        dc0 = done_count;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        check_eq("abort_no_done", done_count - dc0, 0);
        run_block(K1, P1, ct);
        check_eq("post_rst_kat", ct, C1);

        // Inputs change right after the accept edge.
        @(negedge clk);
        bus.start = 1'b1; bus.key = K2; bus.plaintext = P2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.key = {$urandom, $urandom, $urandom, $urandom};
        bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
        wait_done(ct);
        check_eq("sampled_inputs", ct, C2);

        repeat (3) @(negedge clk);
        check_eq("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
